// File: rtl/traffic_control_adaptive.sv
// Adaptive round-robin traffic light controller with all-red clearance and emergency preemption.
// Optional end-of-round pedestrian walk interval is enabled by defining TRAFFIC_PED_PHASE_EN.

module traffic_control_adaptive #(
  parameter int N_DIR         = 4,
  parameter int DW            = 2,
  parameter int GREEN_UNIT    = 4,
  parameter int YELLOW_CYCLES = 4,
  parameter int ALLRED_CYCLES = 2
`ifdef TRAFFIC_PED_PHASE_EN
  ,
  parameter int PED_CYCLES    = 8
`endif
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic [N_DIR*DW-1:0]      traffic_density,
  input  logic                     emg_req,
  input  logic [$clog2(N_DIR)-1:0] emg_dir,
`ifdef TRAFFIC_PED_PHASE_EN
  input  logic                     ped_req,
  output logic                     walk,
`endif
  output logic [3*N_DIR-1:0]       lights,
  output logic [$clog2(N_DIR)-1:0] active_dir,
  output logic [1:0]               phase,
  output logic                     emg_active
);

  localparam int DIRW      = $clog2(N_DIR);
  localparam int GREEN_MAX = GREEN_UNIT * (2 ** DW);
  localparam int T0        = (GREEN_MAX > YELLOW_CYCLES) ? GREEN_MAX : YELLOW_CYCLES;
  localparam int T1        = (T0 > ALLRED_CYCLES) ? T0 : ALLRED_CYCLES;
`ifdef TRAFFIC_PED_PHASE_EN
  localparam int TMAX      = (T1 > PED_CYCLES) ? T1 : PED_CYCLES;
`else
  localparam int TMAX      = T1;
`endif
  localparam int TW        = $clog2(TMAX + 1);

  localparam logic [TW-1:0]      T_ONE    = TW'(1);
  localparam logic [DIRW-1:0]    LAST_DIR = DIRW'(N_DIR - 1);
  localparam logic [DIRW:0]      NDIR_L   = (DIRW + 1)'(N_DIR);
  localparam logic [3*N_DIR-1:0] ALL_RED  = {N_DIR{3'b100}};

  typedef enum logic [1:0] {
    ALLRED    = 2'b00,
    GREEN     = 2'b01,
    YELLOW    = 2'b10,
    EMG_GREEN = 2'b11
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic [DIRW-1:0]   active_n;
  logic [DIRW-1:0]   next_dir, next_n;
  logic [DW-1:0]     dens_sel;
  logic              emg_valid;
  logic              take_exit;
`ifdef TRAFFIC_PED_PHASE_EN
  logic              walk_n;
  logic              ped_flag;
  logic              ped_due, ped_due_n;
  logic              ped_clr;
`endif

  function automatic logic [TW-1:0] green_load(input logic [DW-1:0] d);
    return TW'(GREEN_UNIT * (int'(d) + 1));
  endfunction

  function automatic logic [DIRW-1:0] step_dir(input logic [DIRW-1:0] d);
    return (d == LAST_DIR) ? '0 : d + DIRW'(1);
  endfunction

  function automatic logic [3*N_DIR-1:0] lamp_decode(input state_t s, input logic [DIRW-1:0] d);
    logic [3*N_DIR-1:0] l;
    l = ALL_RED;
    for (int i = 0; i < N_DIR; i++) begin
      if (i == int'(d)) begin
        if (s == GREEN || s == EMG_GREEN) l[3*i +: 3] = 3'b001;
        else if (s == YELLOW)             l[3*i +: 3] = 3'b010;
      end
    end
    return l;
  endfunction

  // An out-of-range emergency direction is treated as no request at all.
  assign emg_valid = emg_req && ({1'b0, emg_dir} < NDIR_L);
  assign dens_sel  = traffic_density[int'(next_dir) * DW +: DW];
  assign phase     = state;

  always_comb begin
    state_n   = state;
    timer_n   = (timer != '0) ? timer - T_ONE : timer;
    active_n  = active_dir;
    next_n    = next_dir;
    take_exit = 1'b0;
`ifdef TRAFFIC_PED_PHASE_EN
    walk_n    = walk;
    ped_due_n = ped_due;
    ped_clr   = 1'b0;
`endif
    case (state)
      ALLRED: begin
        if (timer <= T_ONE) begin
`ifdef TRAFFIC_PED_PHASE_EN
          if (ped_due && !walk) begin
            walk_n  = 1'b1;
            timer_n = TW'(PED_CYCLES);
          end else begin
            walk_n    = 1'b0;
            ped_due_n = 1'b0;
            ped_clr   = walk;
            take_exit = 1'b1;
          end
`else
          take_exit = 1'b1;
`endif
        end
      end
      GREEN: begin
        // Emergency on the served approach extends the green without a yellow.
        if (emg_valid && emg_dir == active_dir) begin
          state_n = EMG_GREEN;
        end else if (emg_valid || timer <= T_ONE) begin
          state_n = YELLOW;
          timer_n = TW'(YELLOW_CYCLES);
          next_n  = step_dir(active_dir);
        end
      end
      YELLOW: begin
        if (timer <= T_ONE) begin
          state_n = ALLRED;
          timer_n = TW'(ALLRED_CYCLES);
`ifdef TRAFFIC_PED_PHASE_EN
          ped_due_n = ped_flag && (active_dir == LAST_DIR);
`endif
        end
      end
      EMG_GREEN: begin
        timer_n = timer;
        if (!emg_req) begin
          state_n = YELLOW;
          timer_n = TW'(YELLOW_CYCLES);
          next_n  = step_dir(active_dir);
        end
      end
      default: ;
    endcase
    if (take_exit) begin
      if (emg_valid) begin
        state_n  = EMG_GREEN;
        active_n = emg_dir;
      end else begin
        state_n  = GREEN;
        active_n = next_dir;
        timer_n  = green_load(dens_sel);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      state      <= ALLRED;
      timer      <= TW'(ALLRED_CYCLES);
      active_dir <= '0;
      next_dir   <= '0;
      lights     <= ALL_RED;
      emg_active <= 1'b0;
`ifdef TRAFFIC_PED_PHASE_EN
      walk       <= 1'b0;
      ped_flag   <= 1'b0;
      ped_due    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      active_dir <= active_n;
      next_dir   <= next_n;
      lights     <= lamp_decode(state_n, active_n);
      emg_active <= (state_n == EMG_GREEN);
`ifdef TRAFFIC_PED_PHASE_EN
      walk       <= walk_n;
      ped_flag   <= (ped_flag & ~ped_clr) | ped_req;
      ped_due    <= ped_due_n;
`endif
    end
  end

endmodule

// File: doc/traffic_control_adaptive.md
Name: traffic_control_adaptive

Overview:
- Parametrised next-generation adaptive traffic light controller for an N_DIR-approach intersection.
- Serves approaches round-robin. Each green time scales with that approach's sampled traffic density.
- Inserts an all-red clearance interval between phases.
- Supports emergency-vehicle preemption of any approach. Sits between the density sensors/emergency receiver and the lamp drivers.

Parameters:
- N_DIR, 4, number of approaches (2..8); index 0 = North, then clockwise.
- DW, 2, density input width per approach.
- GREEN_UNIT, 4, green cycles per density step; green = GREEN_UNIT*(density+1).
- YELLOW_CYCLES, 4, yellow duration in cycles (>=1).
- ALLRED_CYCLES, 2, all-red clearance duration in cycles (>=1).

Ports:
- clk, input, 1: rising-edge clock.
- rst_a, input, 1: reset, synchronous, active-low.
- traffic_density, input, N_DIR*DW: packed densities; approach i at [i*DW +: DW].
- emg_req, input, 1: level emergency preemption request.
- emg_dir, input, clog2(N_DIR): approach requested by emergency.
- lights, output, 3*N_DIR: approach i at [3i +: 3], encoded {R,Y,G}: red=100, yellow=010, green=001.
- active_dir, output, clog2(N_DIR): approach currently green/yellow, or last served approach during all-red.
- phase, output, 2: 00 ALLRED, 01 GREEN, 10 YELLOW, 11 EMG_GREEN.
- emg_active, output, 1: high while in EMG_GREEN.

Behaviour:
- All outputs registered. Reset is sampled at posedge while rst_a=0, and applies mid-operation too.
- Reset values: all lights=100, active_dir=0, phase=00, emg_active=0, state ALLRED, timer loaded with ALLRED_CYCLES, next_dir=0.
- Exactly one approach is ever non-red. Every other approach is always 100.
- ALLRED: holds ALLRED_CYCLES cycles.
  - If a valid emergency is pending (emg_req=1 and emg_dir<N_DIR), go to EMG_GREEN on emg_dir.
  - Otherwise go to GREEN on next_dir.
- GREEN entry: samples density of the served approach in that same cycle and loads timer = GREEN_UNIT*(d+1). Density changes during green are ignored. Timer width is sized for GREEN_UNIT*2^DW.
- GREEN: lamp 001 for exactly the loaded cycle count, then YELLOW. next_dir = (active_dir+1) mod N_DIR, wrapping at N_DIR-1 to 0.
- GREEN with valid emergency:
  - emg_dir != active_dir: abort the green immediately. Next cycle is YELLOW (full YELLOW_CYCLES), then ALLRED.
  - emg_dir == active_dir: transition directly to EMG_GREEN on the next cycle with no yellow; lamp stays 001.
- YELLOW: lamp 010 for YELLOW_CYCLES, then ALLRED. An emergency arriving in YELLOW or ALLRED does not shorten either interval; it is taken at the ALLRED exit.
- EMG_GREEN:
  - Lamp 001 on emg_dir (latched at entry), emg_active=1, held indefinitely while emg_req=1.
  - On emg_req=0: YELLOW on that approach, then ALLRED, then resume normal rotation at (emg_dir+1) mod N_DIR.
  - Changes to emg_dir while in EMG_GREEN are ignored.
- Invalid emg_dir (>=N_DIR): the request is ignored entirely.
- Simultaneous green expiry and emergency request: the emergency rule takes priority, but the outcome is identical (YELLOW next).

Optional Feature:
- Macro: TRAFFIC_PED_PHASE_EN.
- When defined, adds ports:
  - ped_req, input, 1: pulse, latched into a sticky flag.
  - walk, output, 1: reset 0.
  - Parameter PED_CYCLES, default 8.
- After the YELLOW of approach N_DIR-1 (end of a full round), if the flag is set:
  - ALLRED is extended by PED_CYCLES with walk=1 and all lights 100.
  - The flag is then cleared and rotation continues at approach 0.
- Emergency requests are taken at the end of the walk interval.
- When undefined, no ped ports exist and behaviour is exactly as above.

Test Plan:
- Defaults for all scenarios: N_DIR=4, GREEN_UNIT=4, YELLOW=4, ALLRED=2, 10 ns clock.
- Reset and startup: rst_a=0 for 2 cycles, then 1 → lights=0x924 (all red) for 2 cycles. Then N green 4 cycles (density 0), yellow 4, all-red 2, then E green.
- Density scaling: N=10, E=01, S=11, W=00 held → green lengths 12/8/16/4 cycles in order N,E,S,W. Then wraps to N.
- Latching: N density 00 at green entry, changed to 11 mid-green → N green stays 4 cycles.
- Preemption: during N green (cycle 2), emg_req=1, emg_dir=2 → N yellow 4, all-red 2, S 001 with emg_active=1 and phase=11. Drop emg_req after 10 cycles → S yellow 4, all-red 2, W green.
- Emergency on the active approach: during E green, emg_req=1, emg_dir=1 → no yellow, E stays green, phase 01→11. Invalid emg_dir with N_DIR=3 is ignored.
- Reset mid-operation: rst_a=0 one cycle during S yellow → next cycle all red, phase=00. Rotation restarts at N.
